// File: rtl/dffr_pipe_pkg.sv
// Shared definitions for the dffr_pipe elastic register pipeline.
// Holds the default geometry and the occupancy-counter width helper,
// which both the interface and the top need to agree on.
package dffr_pipe_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  // The occupancy counter must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dffr_pipe_if.sv
// Valid/ready bus of the dffr_pipe pipeline.
// Ports (signals):
//   in_valid/in_ready/in_data     upstream handshake into stage 0
//   out_valid/out_ready/out_data  downstream handshake from the last stage
//   count                         number of valid stages (0..DEPTH)
// Modports: master = producer/consumer side, slave = the pipeline.
interface dffr_pipe_if
  import dffr_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);

  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_data;
  logic [cnt_w(DEPTH)-1:0]   count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );

endinterface

// File: rtl/dffr_pipe_stage.sv
// One pipeline stage: a valid flag plus WIDTH data flops.
// Ports:
//   clk, r_n   clock, async active-low reset (clears valid and data)
//   en         stage advances this cycle
//   clr        synchronous flush of the valid flag (data kept)
//   v_in,d_in  upstream stage contents
//   v, d       this stage's contents
module dffr_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             r_n,
  input  logic             en,
  input  logic             clr,
  input  logic             v_in,
  input  logic [WIDTH-1:0] d_in,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      v <= 1'b0;
      d <= '0;
    end else begin
      if (clr) begin
        v <= 1'b0;
      end else if (en) begin
        v <= v_in;
      end
      // Data only moves with a real beat, so a loaded bubble leaves the
      // previous payload in place and garbage on an idle input never lands.
      if (en && v_in && !clr) begin
        d <= d_in;
      end
    end
  end

endmodule

// File: rtl/dffr_pipe.sv
// Elastic register pipeline: DEPTH stages of WIDTH-bit flops with
// valid/ready flow control, optional bubble collapsing, flush and occupancy.
// Ports:
//   clk    clock, all state on posedge
//   r_n    async active-low reset (release synchronised externally)
//   clr    synchronous flush of all stages, highest priority
//   bus    dffr_pipe_if slave: in_* handshake, out_* handshake, count
// out_data is the last stage register; out_ready reaches in_ready
// combinationally through the enable chain.
module dffr_pipe
  import dffr_pipe_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int COLLAPSE = 1
) (
  input  logic       clk,
  input  logic       r_n,
  input  logic       clr,
  dffr_pipe_if.slave bus
);

  localparam int CW = cnt_w(DEPTH);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] en;
  logic [WIDTH-1:0] d [DEPTH];
  logic             acc;
  logic [CW-1:0]    count_q;
  logic             in_fire;
  logic             out_fire;

  // Enable chain built from the output end backwards. With collapsing, a
  // stage advances when it is empty or its successor is taking its beat;
  // otherwise the whole pipe moves together unless the last stage is stuck.
  always_comb begin
    en  = '0;
    acc = bus.out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (COLLAPSE != 0) begin
        en[i] = ~v[i] | acc;
      end else begin
        en[i] = bus.out_ready | ~v[DEPTH-1];
      end
      acc = en[i];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             v_up;
    logic [WIDTH-1:0] d_up;

    if (i == 0) begin : g_head
      assign v_up = bus.in_valid;
      assign d_up = bus.in_data;
    end else begin : g_body
      assign v_up = v[i-1];
      assign d_up = d[i-1];
    end

    dffr_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk  (clk),
      .r_n  (r_n),
      .en   (en[i]),
      .clr  (clr),
      .v_in (v_up),
      .d_in (d_up),
      .v    (v[i]),
      .d    (d[i])
    );
  end

  // clr blocks both handshakes so nothing fires in the flush cycle;
  // r_n gating keeps in_ready low for the whole time reset is held.
  assign bus.in_ready  = en[0] & ~clr & r_n;
  assign bus.out_valid = v[DEPTH-1] & ~clr;
  assign bus.out_data  = d[DEPTH-1];

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (in_fire && !out_fire) begin
      count_q <= count_q + 1'b1;
    end else if (out_fire && !in_fire) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign bus.count = count_q;

endmodule
